// File: rtl/doppler_sweep_ctrl.sv
// Doppler-bin sweep sequencer for the DDS carrier-wipeoff datapath: per bin it programs the
// phase increment, drops DDS settle samples, then forwards a fixed number of front-end samples.
module doppler_sweep_ctrl #(
    parameter int unsigned PINC_W        = 32,
    parameter int unsigned BIN_W         = 8,
    parameter int unsigned SAMP_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              start,
    input  logic              abort,
    input  logic [PINC_W-1:0] pinc_start,
    input  logic [PINC_W-1:0] pinc_step,
    input  logic [BIN_W-1:0]  num_bins,
    input  logic [SAMP_W-1:0] samples_per_bin,
    output logic [PINC_W-1:0] cfg_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    input  logic [1:0]        smp_in,
    input  logic              smp_in_valid,
    output logic [1:0]        smp_out,
    output logic              smp_out_valid,
    output logic [BIN_W-1:0]  bin_idx,
    output logic              bin_start,
    output logic              bin_done,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SET_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SET_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_SETTLE,
        S_INTEG,
        S_NEXT
    } state_e;

    state_e             state_q;
    logic [PINC_W-1:0]  pinc_q;
    logic [PINC_W-1:0]  step_q;
    logic [BIN_W-1:0]   nbins_q;
    logic [SAMP_W-1:0]  spb_q;
    logic [BIN_W-1:0]   bin_q;
    logic [SET_W-1:0]   settle_q;
    logic [SAMP_W-1:0]  cnt_q;
    logic               abort_pend_q;
    logic               cfg_tvalid_q;
    logic [1:0]         smp_out_q;
    logic               smp_out_valid_q;
    logic               bin_start_q;
    logic               bin_done_q;
    logic               busy_q;
    logic               done_q;

    logic cfg_hs_c;
    logic last_bin_c;
    logic last_smp_c;
    logic settle_end_c;

    assign cfg_hs_c     = cfg_tvalid_q && cfg_tready;
    assign last_bin_c   = (bin_q == (nbins_q - BIN_W'(1)));
    assign last_smp_c   = (cnt_q == (spb_q - SAMP_W'(1)));
    assign settle_end_c = (settle_q == SET_W'(SET_LAST));

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q         <= S_IDLE;
            pinc_q          <= '0;
            step_q          <= '0;
            nbins_q         <= '0;
            spb_q           <= '0;
            bin_q           <= '0;
            settle_q        <= '0;
            cnt_q           <= '0;
            abort_pend_q    <= 1'b0;
            cfg_tvalid_q    <= 1'b0;
            smp_out_q       <= '0;
            smp_out_valid_q <= 1'b0;
            bin_start_q     <= 1'b0;
            bin_done_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            bin_start_q     <= 1'b0;
            bin_done_q      <= 1'b0;
            done_q          <= 1'b0;
            smp_out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    abort_pend_q <= 1'b0;
                    if (start && !abort) begin
                        if ((num_bins != '0) && (samples_per_bin != '0)) begin
                            pinc_q       <= pinc_start;
                            step_q       <= pinc_step;
                            nbins_q      <= num_bins;
                            spb_q        <= samples_per_bin;
                            bin_q        <= '0;
                            cfg_tvalid_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_CFG;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                // tvalid is never withdrawn before the handshake; an abort waits for it
                S_CFG: begin
                    if (cfg_hs_c) begin
                        cfg_tvalid_q <= 1'b0;
                        if (abort || abort_pend_q) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (SETTLE_CYCLES == 0) begin
                            cnt_q       <= '0;
                            bin_start_q <= 1'b1;
                            state_q     <= S_INTEG;
                        end else begin
                            settle_q <= '0;
                            state_q  <= S_SETTLE;
                        end
                    end else if (abort) begin
                        abort_pend_q <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (settle_end_c) begin
                        cnt_q       <= '0;
                        bin_start_q <= 1'b1;
                        state_q     <= S_INTEG;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                // abort beats a coincident final sample
                S_INTEG: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        smp_out_q       <= smp_in;
                        smp_out_valid_q <= smp_in_valid;
                        if (smp_in_valid) begin
                            cnt_q <= cnt_q + SAMP_W'(1);
                            if (last_smp_c) begin
                                bin_done_q <= 1'b1;
                                state_q    <= S_NEXT;
                            end
                        end
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (last_bin_c) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        bin_q        <= bin_q + BIN_W'(1);
                        pinc_q       <= pinc_q + step_q;
                        cfg_tvalid_q <= 1'b1;
                        state_q      <= S_CFG;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_tdata     = pinc_q;
    assign cfg_tvalid    = cfg_tvalid_q;
    assign smp_out       = smp_out_q;
    assign smp_out_valid = smp_out_valid_q;
    assign bin_idx       = bin_q;
    assign bin_start     = bin_start_q;
    assign bin_done      = bin_done_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_doppler_sweep_ctrl.sv
// Scoreboard bench for doppler_sweep_ctrl: the driver queues expected config words, samples and
// bin/sweep events; a monitor pops and compares them whenever the DUT presents them.
module tb_doppler_sweep_ctrl;

    logic        aclk = 1'b0;
    logic        arst;
    logic        start;
    logic        abort;
    logic [31:0] pinc_start;
    logic [31:0] pinc_step;
    logic [7:0]  num_bins;
    logic [15:0] samples_per_bin;
    logic [31:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [1:0]  smp_in;
    logic        smp_in_valid;
    logic [1:0]  smp_out;
    logic        smp_out_valid;
    logic [7:0]  bin_idx;
    logic        bin_start;
    logic        bin_done;
    logic        busy;
    logic        done;

    logic [31:0] exp_cfg[$];
    logic [1:0]  exp_smp[$];
    logic [7:0]  exp_start[$];
    logic [7:0]  exp_bin[$];
    bit          exp_done[$];
    int          n_cmp;
    int          n_fail;

    always #5 aclk = ~aclk;

    doppler_sweep_ctrl #(
        .PINC_W(32), .BIN_W(8), .SAMP_W(16), .SETTLE_CYCLES(2)
    ) dut (
        .aclk(aclk), .arst(arst), .start(start), .abort(abort),
        .pinc_start(pinc_start), .pinc_step(pinc_step), .num_bins(num_bins),
        .samples_per_bin(samples_per_bin), .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
        .cfg_tready(cfg_tready), .smp_in(smp_in), .smp_in_valid(smp_in_valid),
        .smp_out(smp_out), .smp_out_valid(smp_out_valid), .bin_idx(bin_idx),
        .bin_start(bin_start), .bin_done(bin_done), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge aclk);
            if (!arst) begin
                if (cfg_tvalid && cfg_tready) begin
                    if (exp_cfg.size() == 0) chk("cfg_unexpected", 32'(cfg_tvalid), 32'(0));
                    else chk("cfg_tdata", cfg_tdata, exp_cfg.pop_front());
                end
                if (smp_out_valid) begin
                    if (exp_smp.size() == 0) chk("smp_unexpected", 32'(smp_out_valid), 32'(0));
                    else chk("smp_out", 32'(smp_out), 32'(exp_smp.pop_front()));
                end
                if (bin_start) begin
                    if (exp_start.size() == 0) chk("bin_start_unexpected", 32'(bin_start), 32'(0));
                    else chk("bin_start_idx", 32'(bin_idx), 32'(exp_start.pop_front()));
                end
                if (bin_done) begin
                    chk("bin_done_with_valid", 32'(smp_out_valid), 32'(1));
                    if (exp_bin.size() == 0) chk("bin_done_unexpected", 32'(bin_done), 32'(0));
                    else chk("bin_done_idx", 32'(bin_idx), 32'(exp_bin.pop_front()));
                end
                if (done) begin
                    if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 32'(0));
                    else begin
                        void'(exp_done.pop_front());
                        chk("done_busy", 32'(busy), 32'(0));
                    end
                end
            end
        end
    endtask

    // Waits for INTEG entry while feeding samples that must be dropped
    task automatic wait_bin_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bin_start) begin
                ok = 1'b1;
                return;
            end
            smp_in       = 2'($urandom);
            smp_in_valid = 1'b1;
            tick();
        end
        chk("bin_start_timeout", 32'(bin_start), 32'(1));
    endtask

    task automatic feed(input int spb, input int mode, input int ab_after);
        int         cnt;
        bit         v;
        logic [1:0] d;
        cnt = 0;
        v   = 1'b1;
        while (cnt < spb) begin
            d = 2'($urandom);
            if (ab_after >= 0 && cnt == ab_after) begin
                abort        = 1'b1;
                smp_in       = d;
                smp_in_valid = 1'b1;
                tick();
                abort        = 1'b0;
                smp_in_valid = 1'b0;
                chk("abort_busy", 32'(busy), 32'(0));
                chk("abort_smp_valid", 32'(smp_out_valid), 32'(0));
                chk("abort_tvalid", 32'(cfg_tvalid), 32'(0));
                return;
            end
            smp_in       = d;
            smp_in_valid = v;
            if (v) begin
                exp_smp.push_back(d);
                cnt++;
            end
            tick();
            if (mode == 1) v = ~v;
        end
        smp_in       = 2'($urandom);
        smp_in_valid = 1'b1;
        tick();
        smp_in_valid = 1'b0;
    endtask

    task automatic run_sweep(input logic [31:0] ps, input logic [31:0] st, input int nb,
                             input int spb, input int mode, input int hold,
                             input int abort_bin, input int abort_after);
        logic [31:0] p;
        int          last;
        bit          ok;
        last = (abort_bin >= 0) ? abort_bin : nb - 1;
        p    = ps;
        for (int b = 0; b <= last; b++) begin
            exp_cfg.push_back(p);
            exp_start.push_back(8'(b));
            if (b != abort_bin) exp_bin.push_back(8'(b));
            p = p + st;
        end
        if (abort_bin < 0) exp_done.push_back(1'b1);
        pinc_start      = ps;
        pinc_step       = st;
        num_bins        = 8'(nb);
        samples_per_bin = 16'(spb);
        start           = 1'b1;
        tick();
        start           = 1'b0;
        pinc_start      = $urandom;
        pinc_step       = $urandom;
        num_bins        = 8'($urandom);
        samples_per_bin = 16'($urandom_range(1, 3));
        p = ps;
        for (int b = 0; b <= last; b++) begin
            if (b == 0 && hold > 0) begin
                cfg_tready = 1'b0;
                for (int i = 0; i < hold; i++) begin
                    chk("hold_tvalid", 32'(cfg_tvalid), 32'(1));
                    chk("hold_tdata", cfg_tdata, p);
                    chk("hold_smp_valid", 32'(smp_out_valid), 32'(0));
                    smp_in       = 2'($urandom);
                    smp_in_valid = 1'b1;
                    tick();
                end
                cfg_tready = 1'b1;
            end
            wait_bin_start(ok);
            if (!ok) return;
            feed(spb, mode, (b == abort_bin) ? abort_after : -1);
            p = p + st;
        end
        smp_in_valid = 1'b0;
        repeat (4) tick();
        chk("sweep_end_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        bit         ok;
        logic [1:0] d0;
        n_cmp = 0; n_fail = 0;
        arst = 1'b1; start = 1'b0; abort = 1'b0; cfg_tready = 1'b1;
        pinc_start = '0; pinc_step = '0; num_bins = '0; samples_per_bin = '0;
        smp_in = '0; smp_in_valid = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("reset_cfg_tdata", cfg_tdata, 32'(0));
        chk("reset_ctrl", 32'({cfg_tvalid, smp_out, smp_out_valid, bin_idx, bin_start,
                               bin_done, busy, done}), 32'(0));
        arst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'(0));

        run_sweep(32'h0000_1000, 32'h0000_0100, 3, 4, 0, 0, -1, -1);
        run_sweep(32'hABCD_0000, 32'h0000_0010, 1, 2, 0, 10, -1, -1);
        run_sweep(32'h0000_2000, 32'h0000_0040, 2, 5, 1, 0, -1, -1);
        run_sweep(32'hFFFF_FF00, 32'h0000_0200, 2, 1, 0, 0, -1, -1);
        run_sweep(32'h0000_3000, 32'h0000_0100, 3, 4, 0, 0, 1, 3);

        // abort in CFG with tready low: held until the handshake
        exp_cfg.push_back(32'h0000_5000);
        pinc_start = 32'h0000_5000; pinc_step = 32'h1; num_bins = 8'd2; samples_per_bin = 16'd3;
        cfg_tready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("cfg_abort_tvalid", 32'(cfg_tvalid), 32'(1));
            chk("cfg_abort_tdata", cfg_tdata, 32'h0000_5000);
            chk("cfg_abort_busy", 32'(busy), 32'(1));
            tick();
        end
        cfg_tready = 1'b1;
        tick();
        chk("cfg_abort_end_busy", 32'(busy), 32'(0));
        chk("cfg_abort_end_tvalid", 32'(cfg_tvalid), 32'(0));
        repeat (4) tick();

        // zero counts: immediate done, no config
        exp_done.push_back(1'b1);
        num_bins = 8'd0; samples_per_bin = 16'd4;
        start = 1'b1; tick(); start = 1'b0;
        chk("zero_bins_done", 32'(done), 32'(1));
        chk("zero_bins_tvalid", 32'(cfg_tvalid), 32'(0));
        repeat (3) tick();
        chk("zero_bins_tvalid_later", 32'(cfg_tvalid), 32'(0));
        exp_done.push_back(1'b1);
        num_bins = 8'd3; samples_per_bin = 16'd0;
        start = 1'b1; tick(); start = 1'b0;
        chk("zero_spb_done", 32'(done), 32'(1));
        chk("zero_spb_busy", 32'(busy), 32'(0));
        repeat (3) tick();

        // asynchronous reset mid-INTEG
        exp_cfg.push_back(32'h0000_7000);
        exp_start.push_back(8'd0);
        pinc_start = 32'h0000_7000; pinc_step = 32'h10; num_bins = 8'd2; samples_per_bin = 16'd4;
        start = 1'b1; tick(); start = 1'b0;
        wait_bin_start(ok);
        if (ok) begin
            d0 = 2'($urandom);
            smp_in = d0; smp_in_valid = 1'b1;
            exp_smp.push_back(d0);
            tick();
            smp_in = 2'b11; smp_in_valid = 1'b1;
            @(posedge aclk);
            #2 arst = 1'b1;
            #1;
            chk("arst_cfg_tdata", cfg_tdata, 32'(0));
            chk("arst_ctrl", 32'({cfg_tvalid, smp_out, smp_out_valid, bin_idx, bin_start,
                                 bin_done, busy, done}), 32'(0));
        end
        smp_in_valid = 1'b0;
        tick();
        arst = 1'b0;
        repeat (5) tick();
        chk("post_arst_busy", 32'(busy), 32'(0));

        chk("left_cfg", 32'(exp_cfg.size()), 32'(0));
        chk("left_smp", 32'(exp_smp.size()), 32'(0));
        chk("left_bin_start", 32'(exp_start.size()), 32'(0));
        chk("left_bin_done", 32'(exp_bin.size()), 32'(0));
        chk("left_done", 32'(exp_done.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
